// File: rtl/transmitor.sv
// transmitor: message table -> extended Hamming(8,4) -> dibit/QPSK Gray map -> optional
// single-bit channel error -> demap -> registered received dibit (optional ECC receiver).
// Latency 2 enabled edges (6 with ERROR_CORRECT_EN); IsTransmit=0 freezes every register.
// Ports: sys_clk, reset (sync, active-low), init_tab (reload table), has_error (inject one
// error per codeword), IsTransmit (advance one dibit/clock), demodulation_out[1:0] (registered).
// Optional feature macro: ERROR_CORRECT_EN (single-error-correcting receiver with replay).
module transmitor (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       init_tab,
  input  logic       has_error,
  input  logic       IsTransmit,
  output logic [1:0] demodulation_out
);

  // Power-on contents equal the init_tab defaults: entry i = {i, ~i}.
  logic [7:0] r_tab [16] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78,
                             8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
  logic [3:0] r_addr    = 4'd0;
  logic [2:0] r_k       = 3'd0;   // [2] selects nibble, [1:0] selects dibit
  logic [2:0] r_err_pos = 3'd0;
  logic [1:0] r_tx_sym  = 2'b00;
  logic [1:0] r_out     = 2'b00;

  logic [7:0] w_byte;
  logic [3:0] w_nib;
  logic [7:0] w_cw;
  logic [7:0] w_err_mask;
  logic [7:0] w_cw_tx;
  logic [1:0] w_dibit;
  logic [1:0] w_rx;
  logic       w_en;

  function automatic logic [1:0] qpsk_map(input logic [1:0] d);
    case (d)
      2'b00:   qpsk_map = 2'd0;
      2'b01:   qpsk_map = 2'd1;
      2'b11:   qpsk_map = 2'd2;
      default: qpsk_map = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] qpsk_demap(input logic [1:0] ph);
    case (ph)
      2'd0:    qpsk_demap = 2'b00;
      2'd1:    qpsk_demap = 2'b01;
      2'd2:    qpsk_demap = 2'b11;
      default: qpsk_demap = 2'b10;
    endcase
  endfunction

  assign w_en   = reset && !init_tab && IsTransmit;
  assign w_byte = r_tab[r_addr];
  assign w_nib  = r_k[2] ? w_byte[3:0] : w_byte[7:4];

  always_comb begin
    w_cw[7:4] = w_nib;
    w_cw[3]   = w_nib[3] ^ w_nib[2] ^ w_nib[0];
    w_cw[2]   = w_nib[3] ^ w_nib[1] ^ w_nib[0];
    w_cw[1]   = w_nib[2] ^ w_nib[1] ^ w_nib[0];
    w_cw[0]   = ^w_cw[7:1];
  end

  assign w_err_mask = has_error ? (8'b1 << r_err_pos) : 8'h00;
  assign w_cw_tx    = w_cw ^ w_err_mask;

  always_comb begin
    w_dibit = 2'b00;
    case (r_k[1:0])
      2'd0:    w_dibit = w_cw_tx[7:6];
      2'd1:    w_dibit = w_cw_tx[5:4];
      2'd2:    w_dibit = w_cw_tx[3:2];
      default: w_dibit = w_cw_tx[1:0];
    endcase
  end

  // Channel: the phase is mapped and immediately demapped by the receiver.
  assign w_rx = qpsk_demap(qpsk_map(r_tx_sym));

  // Table storage has no reset; reset still wins over a simultaneous init_tab.
  always_ff @(posedge sys_clk) begin
    if (reset && init_tab) begin
      for (int i = 0; i < 16; i++) begin
        r_tab[i] <= {4'(i), ~4'(i)};
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_addr    <= 4'd0;
      r_k       <= 3'd0;
      r_err_pos <= 3'd0;
      r_tx_sym  <= 2'b00;
    end else if (init_tab) begin
      r_addr <= 4'd0;
      r_k    <= 3'd0;
    end else if (IsTransmit) begin
      r_tx_sym <= w_dibit;
      r_k      <= r_k + 3'd1;
      if (r_k == 3'd7) r_addr <= r_addr + 4'd1;
      if (has_error && (r_k[1:0] == 2'd3)) r_err_pos <= r_err_pos + 3'd1;
    end
  end

`ifdef ERROR_CORRECT_EN
  // Receiver collects 4 raw dibits, corrects the codeword, then replays it MSB first.
  logic [1:0] r_raw    = 2'b00;
  logic [1:0] r_tx_ph  = 2'd0;  // dibit index travelling with r_tx_sym
  logic [1:0] r_raw_ph = 2'd0;  // dibit index travelling with r_raw
  logic [5:0] r_sh     = 6'd0;
  logic [7:0] r_hold   = 8'd0;
  logic [7:0] w_rx_cw;
  logic [2:0] w_syn;
  logic [7:0] w_flip;
  logic [7:0] w_fix;

  assign w_rx_cw = {r_sh, r_raw};
  assign w_syn   = {w_rx_cw[3] ^ w_rx_cw[7] ^ w_rx_cw[6] ^ w_rx_cw[4],
                    w_rx_cw[2] ^ w_rx_cw[7] ^ w_rx_cw[5] ^ w_rx_cw[4],
                    w_rx_cw[1] ^ w_rx_cw[6] ^ w_rx_cw[5] ^ w_rx_cw[4]};

  // Odd overall parity means a single error; even parity with a nonzero syndrome is a
  // double error and is passed through untouched.
  always_comb begin
    w_flip = 8'h00;
    if (^w_rx_cw) begin
      case (w_syn)
        3'b110:  w_flip = 8'h80;
        3'b101:  w_flip = 8'h40;
        3'b011:  w_flip = 8'h20;
        3'b111:  w_flip = 8'h10;
        3'b100:  w_flip = 8'h08;
        3'b010:  w_flip = 8'h04;
        3'b001:  w_flip = 8'h02;
        default: w_flip = 8'h01;
      endcase
    end
  end
  assign w_fix = w_rx_cw ^ w_flip;

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_raw    <= 2'b00;
      r_tx_ph  <= 2'd0;
      r_raw_ph <= 2'd0;
      r_sh     <= 6'd0;
      r_hold   <= 8'd0;
      r_out    <= 2'b00;
    end else if (w_en) begin
      r_raw    <= w_rx;
      r_tx_ph  <= r_k[1:0];
      r_raw_ph <= r_tx_ph;
      r_sh     <= {r_sh[3:0], r_raw};
      case (r_raw_ph)
        2'd3: begin
          r_hold <= w_fix;
          r_out  <= w_fix[7:6];
        end
        2'd0:    r_out <= r_hold[5:4];
        2'd1:    r_out <= r_hold[3:2];
        default: r_out <= r_hold[1:0];
      endcase
    end
  end
`else
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_out <= 2'b00;
    end else if (w_en) begin
      r_out <= w_rx;
    end
  end
`endif

  assign demodulation_out = r_out;

endmodule

// File: tb/tb_transmitor.sv
// Directed bench for transmitor (default build, no error correction).
// Covers reset, latency, table wrap, hold, init_tab, reset+init and error injection.
module tb_transmitor;

  logic       sys_clk    = 1'b0;
  logic       reset      = 1'b0;
  logic       init_tab   = 1'b0;
  logic       has_error  = 1'b0;
  logic       IsTransmit = 1'b0;
  logic [1:0] demodulation_out;

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-computed dibit streams.
  logic [1:0] v_e0  [8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
  logic [1:0] v_e1  [8]  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};
  logic [1:0] v_e15 [8]  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
  // 0x00^bit0, 0xFF^bit1, 0x1E^bit2, 0xE1^bit3
  logic [1:0] v_err [16] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01,
                             2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01};

  always #5 sys_clk = ~sys_clk;

  transmitor dut (
    .sys_clk          (sys_clk),
    .reset            (reset),
    .init_tab         (init_tab),
    .has_error        (has_error),
    .IsTransmit       (IsTransmit),
    .demodulation_out (demodulation_out)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] exp);
    n_assert++;
    assert (demodulation_out === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, demodulation_out, exp);
    end
  endtask

  initial begin
    // Reset edge
    step();
    check("reset", 2'b00);

    // Scenario 1: plain stream, latency 2
    reset      = 1'b1;
    IsTransmit = 1'b1;
    step();
    check("latency_first_edge", 2'b00);
    for (int i = 0; i < 16; i++) begin
      step();
      if (i < 8) check("stream_entry0", v_e0[i]);
      else       check("stream_entry1", v_e1[i-8]);
    end

    // Scenario 2: run to entry15 and across the address wrap
    for (int idx = 16; idx < 136; idx++) begin
      step();
      if (idx >= 120 && idx < 128) check("wrap_entry15", v_e15[idx-120]);
      else if (idx >= 128)         check("wrap_entry0", v_e0[idx-128]);
    end

    // Scenario 5: hold mid-codeword
    step();
    check("pre_hold_0", v_e1[0]);
    step();
    check("pre_hold_1", v_e1[1]);
    IsTransmit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_frozen", 2'b01);
    end
    IsTransmit = 1'b1;
    step();
    check("resume_2", v_e1[2]);
    step();
    check("resume_3", v_e1[3]);
    step();
    check("resume_4", v_e1[4]);

    // Scenario 6: init_tab pulse mid-stream
    init_tab = 1'b1;
    step();
    check("init_edge_holds", 2'b11);
    init_tab = 1'b0;
    step();
    check("init_flush", 2'b10);
    for (int i = 0; i < 5; i++) begin
      step();
      check("init_restart_entry0", v_e0[i]);
    end
    reset    = 1'b0;
    init_tab = 1'b1;
    step();
    check("reset_with_init", 2'b00);

    // Scenario 3: error injection from reset
    reset     = 1'b1;
    init_tab  = 1'b0;
    has_error = 1'b1;
    step();
    check("err_latency_first_edge", 2'b00);
    for (int i = 0; i < 16; i++) begin
      step();
      check("err_stream", v_err[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
